// File: rtl/cpu_pkg.sv
// Shared RV32I control definitions: opcodes, ExtOp/pc_sel/wb_sel encodings, state enum.
// The TRAP state exists only when CTRL_TRAP_EN is defined.
package cpu_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [31:0] IR_RESET = 32'h0000_0013;

   typedef enum logic [2:0] {
      EXT_I = 3'b000,
      EXT_U = 3'b001,
      EXT_S = 3'b010,
      EXT_B = 3'b011,
      EXT_J = 3'b100
   } ext_op_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'b00,
      PC_REL   = 2'b01,
      PC_JALR  = 2'b10
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_sel_e;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_FENCE,
      CLS_ILLEGAL
   } op_class_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
`ifdef CTRL_TRAP_EN
      ST_WB,
      ST_TRAP
`else
      ST_WB
`endif
   } state_e;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction- and data-memory handshake bundle for the control sequencer.
interface cpu_ctrl_fsm_if;

   logic        instr_req;
   logic        instr_ready;
   logic [31:0] instr_rdata;
   logic        data_req;
   logic        data_we;
   logic        data_ready;

   modport master (
      output instr_req, data_req, data_we,
      input  instr_ready, instr_rdata, data_ready
   );

   modport slave (
      input  instr_req, data_req, data_we,
      output instr_ready, instr_rdata, data_ready
   );

endinterface

// File: rtl/cpu_ctrl_fsm_decode.sv
// Combinational opcode decode: immediate format, operand/writeback/PC selects and opcode class.
module ctrl_decode
   import cpu_pkg::*;
(
   input  logic [6:0] opcode_i,
   output ext_op_e    ext_op_o,
   output logic       alu_a_sel_o,
   output logic       alu_b_sel_o,
   output wb_sel_e    wb_sel_o,
   output pc_sel_e    pc_sel_o,
   output op_class_e  cls_o
);

   always_comb begin
      ext_op_o    = EXT_I;
      alu_a_sel_o = 1'b0;
      alu_b_sel_o = 1'b1;
      wb_sel_o    = WB_ALU;
      pc_sel_o    = PC_PLUS4;
      cls_o       = CLS_ILLEGAL;
      case (opcode_i)
         OPC_LUI: begin
            ext_op_o = EXT_U;
            cls_o    = CLS_ALU;
         end
         OPC_AUIPC: begin
            ext_op_o    = EXT_U;
            alu_a_sel_o = 1'b1;
            cls_o       = CLS_ALU;
         end
         OPC_JAL: begin
            ext_op_o    = EXT_J;
            alu_a_sel_o = 1'b1;
            wb_sel_o    = WB_PC4;
            pc_sel_o    = PC_REL;
            cls_o       = CLS_JUMP;
         end
         OPC_JALR: begin
            wb_sel_o = WB_PC4;
            pc_sel_o = PC_JALR;
            cls_o    = CLS_JUMP;
         end
         OPC_BRANCH: begin
            ext_op_o    = EXT_B;
            alu_a_sel_o = 1'b1;
            cls_o       = CLS_BRANCH;
         end
         OPC_LOAD: begin
            wb_sel_o = WB_MEM;
            cls_o    = CLS_LOAD;
         end
         OPC_STORE: begin
            ext_op_o = EXT_S;
            cls_o    = CLS_STORE;
         end
         OPC_OPIMM: cls_o = CLS_ALU;
         OPC_OP: begin
            alu_b_sel_o = 1'b0;
            cls_o       = CLS_ALU;
         end
         OPC_FENCE: cls_o = CLS_FENCE;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with retired-instruction count.
// Define CTRL_TRAP_EN to make unrecognised opcodes enter a terminal TRAP state instead of a NOP.
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   cpu_ctrl_fsm_if.master    mem,
   input  logic              branch_taken,
   output logic [31:0]       ir,
   output logic [2:0]        ExtOp,
   output logic              alu_a_sel,
   output logic              alu_b_sel,
   output logic [1:0]        wb_sel,
   output logic              reg_we,
   output logic              pc_we,
   output logic [1:0]        pc_sel,
   output logic [CNT_W-1:0]  instret,
   output logic              trap
);

   state_e           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             retire;
   logic             instr_req_d, data_req_d, data_we_d, reg_we_d, pc_we_d;
   pc_sel_e          pc_sel_d;
   logic             in_op;

   ext_op_e          dec_ext;
   logic             dec_a_sel, dec_b_sel;
   wb_sel_e          dec_wb_sel;
   pc_sel_e          dec_pc_sel;
   op_class_e        dec_cls;

   ctrl_decode u_decode (
      .opcode_i    (ir_q[6:0]),
      .ext_op_o    (dec_ext),
      .alu_a_sel_o (dec_a_sel),
      .alu_b_sel_o (dec_b_sel),
      .wb_sel_o    (dec_wb_sel),
      .pc_sel_o    (dec_pc_sel),
      .cls_o       (dec_cls)
   );

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      retire      = 1'b0;
      instr_req_d = 1'b0;
      data_req_d  = 1'b0;
      data_we_d   = 1'b0;
      reg_we_d    = 1'b0;
      pc_we_d     = 1'b0;
      pc_sel_d    = PC_PLUS4;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            instr_req_d = 1'b1;
            if (mem.instr_ready) begin
               ir_d    = mem.instr_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
`ifdef CTRL_TRAP_EN
            state_d = (dec_cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
`else
            state_d = ST_EXEC;
`endif
         end
         ST_EXEC: begin
            case (dec_cls)
               CLS_BRANCH: begin
                  pc_we_d  = 1'b1;
                  pc_sel_d = branch_taken ? PC_REL : PC_PLUS4;
                  retire   = 1'b1;
                  state_d  = ST_FETCH;
               end
               // Illegal opcodes only reach EXEC when trapping is disabled: retire as NOP.
               CLS_FENCE, CLS_ILLEGAL: begin
                  pc_we_d = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               default: state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            data_req_d = 1'b1;
            data_we_d  = (dec_cls == CLS_STORE);
            if (mem.data_ready) begin
               if (dec_cls == CLS_STORE) begin
                  pc_we_d = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            reg_we_d = 1'b1;
            pc_we_d  = 1'b1;
            pc_sel_d = dec_pc_sel;
            retire   = 1'b1;
            state_d  = ST_FETCH;
         end
`ifdef CTRL_TRAP_EN
         ST_TRAP: state_d = ST_TRAP;
`endif
         default: state_d = ST_IDLE;
      endcase
      instret_d = instret_q + CNT_W'(retire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ir_q      <= IR_RESET;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         instret_q <= instret_d;
      end
   end

   assign in_op = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                  (state_q == ST_MEM)    || (state_q == ST_WB);

   assign mem.instr_req = instr_req_d;
   assign mem.data_req  = data_req_d;
   assign mem.data_we   = data_we_d;
   assign reg_we        = reg_we_d;
   assign pc_we         = pc_we_d;
   assign pc_sel        = pc_sel_d;
   assign ir            = ir_q;
   assign instret       = instret_q;
   assign ExtOp         = in_op ? dec_ext : EXT_I;
   assign alu_a_sel     = in_op & dec_a_sel;
   assign alu_b_sel     = in_op & dec_b_sel;
   assign wb_sel        = in_op ? dec_wb_sel : WB_ALU;

`ifdef CTRL_TRAP_EN
   assign trap = (state_q == ST_TRAP);
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed testbench for cpu_ctrl_fsm: per-instruction sequencing, handshakes, retire count, reset.
module tb_cpu_ctrl_fsm;

   logic        clk;
   logic        rst_n;
   logic        branch_taken;
   logic [31:0] ir;
   logic [2:0]  ExtOp;
   logic        alu_a_sel, alu_b_sel;
   logic [1:0]  wb_sel;
   logic        reg_we, pc_we;
   logic [1:0]  pc_sel;
   logic [31:0] instret;
   logic        trap;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned exp_ret  = 0;

   cpu_ctrl_fsm_if bus ();

   cpu_ctrl_fsm #(.CNT_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem          (bus.master),
      .branch_taken (branch_taken),
      .ir           (ir),
      .ExtOp        (ExtOp),
      .alu_a_sel    (alu_a_sel),
      .alu_b_sel    (alu_b_sel),
      .wb_sel       (wb_sel),
      .reg_we       (reg_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .instret      (instret),
      .trap         (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered in a FETCH cycle; leaves the bench in the DECODE cycle.
   task automatic fetch(input logic [31:0] instr, input int unsigned waits);
      for (int unsigned i = 0; i < waits; i++) begin
         check("fetch_wait_req", 64'(bus.instr_req), 64'd1);
         step();
      end
      check("fetch_req", 64'(bus.instr_req), 64'd1);
      bus.instr_rdata = instr;
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
      bus.instr_rdata = '0;
      check("fetch_ir", 64'(ir), 64'(instr));
   endtask

   initial begin
      rst_n           = 1'b0;
      branch_taken    = 1'b0;
      bus.instr_ready = 1'b0;
      bus.instr_rdata = '0;
      bus.data_ready  = 1'b0;
      step();
      step();

      check("rst_ir",      64'(ir),            64'h13);
      check("rst_instret", 64'(instret),       64'd0);
      check("rst_extop",   64'(ExtOp),         64'd0);
      check("rst_trap",    64'(trap),          64'd0);
      check("rst_req",     64'(bus.instr_req), 64'd0);
      check("rst_strobes", 64'({reg_we, pc_we, bus.data_req, alu_a_sel, alu_b_sel, wb_sel, pc_sel}), 64'd0);

      rst_n = 1'b1;
      check("idle_req", 64'(bus.instr_req), 64'd0);
      step();

      // addi x1,x0,5
      fetch(32'h00500093, 0);
      check("addi_extop", 64'(ExtOp),     64'd0);
      check("addi_bsel",  64'(alu_b_sel), 64'd1);
      bus.instr_ready = 1'b1;
      bus.instr_rdata = 32'hDEADBEEF;
      step();
      bus.instr_ready = 1'b0;
      check("stray_ready_ir", 64'(ir), 64'h00500093);
      check("addi_exec_we", 64'({reg_we, pc_we}), 64'd0);
      step();
      check("addi_wb_we",   64'({reg_we, pc_we}), 64'b11);
      check("addi_pc_sel",  64'(pc_sel), 64'd0);
      check("addi_wb_sel",  64'(wb_sel), 64'd0);
      step();
      exp_ret++;
      check("addi_instret", 64'(instret), 64'(exp_ret));

      // beq taken then not taken
      for (int t = 1; t >= 0; t--) begin
         fetch(32'h00208463, 0);
         check("beq_extop", 64'(ExtOp),     64'd3);
         check("beq_asel",  64'(alu_a_sel), 64'd1);
         step();
         branch_taken = (t == 1);
         #1;
         check("beq_pc_we",  64'(pc_we),  64'd1);
         check("beq_pc_sel", 64'(pc_sel), (t == 1) ? 64'd1 : 64'd0);
         check("beq_reg_we", 64'(reg_we), 64'd0);
         step();
         branch_taken = 1'b0;
         exp_ret++;
         check("beq_instret", 64'(instret), 64'(exp_ret));
         check("beq_refetch", 64'(bus.instr_req), 64'd1);
      end

      // lw with data_ready after 3 wait cycles
      fetch(32'h0000a103, 0);
      check("lw_extop", 64'(ExtOp), 64'd0);
      step();
      check("lw_exec_dreq", 64'(bus.data_req), 64'd0);
      step();
      for (int i = 0; i < 4; i++) begin
         check("lw_dreq", 64'(bus.data_req), 64'd1);
         check("lw_dwe",  64'(bus.data_we),  64'd0);
         if (i == 3) bus.data_ready = 1'b1;
         step();
      end
      bus.data_ready = 1'b0;
      check("lw_wb_dreq",   64'(bus.data_req), 64'd0);
      check("lw_wb_sel",    64'(wb_sel), 64'd1);
      check("lw_wb_reg_we", 64'(reg_we), 64'd1);
      step();
      exp_ret++;
      check("lw_instret", 64'(instret), 64'(exp_ret));

      // jalr with two instruction-memory wait cycles
      fetch(32'h000080e7, 2);
      check("jalr_extop", 64'(ExtOp), 64'd0);
      step();
      step();
      check("jalr_wb_sel", 64'(wb_sel), 64'd2);
      check("jalr_pc_sel", 64'(pc_sel), 64'd2);
      check("jalr_reg_we", 64'(reg_we), 64'd1);
      step();
      exp_ret++;
      check("jalr_instret", 64'(instret), 64'(exp_ret));

      // sw with data_ready in the first request cycle
      fetch(32'h0020a023, 0);
      check("sw_extop", 64'(ExtOp), 64'd2);
      step();
      step();
      bus.data_ready = 1'b1;
      #1;
      check("sw_dreq_we", 64'({bus.data_req, bus.data_we}), 64'b11);
      check("sw_pc_we",   64'({pc_we, reg_we}), 64'b10);
      step();
      bus.data_ready = 1'b0;
      exp_ret++;
      check("sw_instret", 64'(instret), 64'(exp_ret));

      // unrecognised opcode 1111111
      fetch(32'h0000007F, 0);
      check("ill_decode_trap", 64'(trap), 64'd0);
      step();
`ifdef CTRL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         check("trap_flag",  64'(trap), 64'd1);
         check("trap_quiet", 64'({bus.instr_req, bus.data_req, pc_we, reg_we}), 64'd0);
         step();
      end
      check("trap_instret", 64'(instret), 64'(exp_ret));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      exp_ret = 0;
`else
      check("ill_nop_pc", 64'({pc_we, pc_sel, reg_we}), 64'b1000);
      check("ill_trap",   64'(trap), 64'd0);
      step();
      exp_ret++;
      check("ill_instret", 64'(instret), 64'(exp_ret));
`endif

      // reset while a load is in MEM
      fetch(32'h0000a103, 0);
      step();
      step();
      check("mem_dreq_before_rst", 64'(bus.data_req), 64'd1);
      #2;
      rst_n          = 1'b0;
      bus.data_ready = 1'b1;
      #1;
      check("rst_mid_dreq",    64'(bus.data_req), 64'd0);
      check("rst_mid_ir",      64'(ir),           64'h13);
      check("rst_mid_instret", 64'(instret),      64'd0);
      step();
      bus.data_ready = 1'b0;
      rst_n = 1'b1;
      check("rst_mid_idle", 64'(bus.instr_req), 64'd0);
      step();
      check("rst_mid_fetch", 64'(bus.instr_req), 64'd1);

      // fence after reset: three-cycle retire
      fetch(32'h0000000F, 0);
      step();
      check("fence_pc", 64'({pc_we, pc_sel, reg_we}), 64'b1000);
      step();
      check("fence_instret", 64'(instret), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
